// File: rtl/nios_sys_mul_pkg.sv
// Shared types and constants for the sequenced 32x32 multiplier built on one 16x16 DSP multiplier.
// The partial-product order and its shift table live here so the issue and accumulate sides agree.
package nios_sys_mul_pkg;

  localparam int OP_W   = 32;
  localparam int RES_W  = 64;
  localparam int HALF_W = 16;
  localparam int ID_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_CORR,
    ST_RESP
  } state_t;

  typedef logic [1:0] pp_idx_t;

  // lo*lo, hi*lo, lo*hi, hi*hi
  localparam logic [5:0] PP_SHIFT [4] = '{6'd0, 6'd16, 6'd16, 6'd32};

  function automatic logic [RES_W-1:0] pp_align(input logic [OP_W-1:0] p, input pp_idx_t idx);
    return {{(RES_W-OP_W){1'b0}}, p} << PP_SHIFT[idx];
  endfunction

endpackage

// File: rtl/nios_sys_mul16_pipe.sv
// 16x16 unsigned multiplier, MUL_LAT register stages, product valid MUL_LAT cycles after inputs.
// No backpressure: a new operand pair is accepted every cycle; reset clears all stages.
module nios_sys_mul16_pipe #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] stage [MUL_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= {16'd0, a} * {16'd0, b};
      for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign p = stage[MUL_LAT-1];

endmodule

// File: rtl/nios_sys_mul_seq_arb.sv
// Round-robin shared 32x32->64 multiplier: result T+5+MUL_LAT after accept (+1 with NIOS_SYS_MUL_SIGNED_EN).
// One request in flight; req_ready only in IDLE, result held until rsp_ready.
module nios_sys_mul_seq_arb
  import nios_sys_mul_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MUL_LAT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_src1,
  input  logic [NUM_REQ*OP_W-1:0] req_src2,
`ifdef NIOS_SYS_MUL_SIGNED_EN
  input  logic [NUM_REQ-1:0]      req_signed,
`endif
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [RES_W-1:0]        rsp_result,
  output logic                    busy
);

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [OP_W-1:0]    op_a;
  logic [OP_W-1:0]    op_b;
  logic [ID_W-1:0]    cur_id;
  pp_idx_t            issue_idx;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   acc_next;
`ifdef NIOS_SYS_MUL_SIGNED_EN
  logic               cur_sgn;
  logic [OP_W-1:0]    corr;
`endif

  logic               gnt_vld;
  int                 gnt_idx;
  int                 cand;

  logic [HALF_W-1:0]  mul_a;
  logic [HALF_W-1:0]  mul_b;
  logic [OP_W-1:0]    mul_p;
  logic               issue_vld;
  logic               tag_vld [MUL_LAT];
  pp_idx_t            tag_idx [MUL_LAT];
  logic               pp_vld;
  pp_idx_t            pp_idx;
  logic               last_pp;

  // Search upward from the pointer with wrap-around; first valid requester wins.
  always_comb begin
    req_ready = '0;
    gnt_vld   = 1'b0;
    gnt_idx   = 0;
    cand      = 0;
    if (state == ST_IDLE) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = (int'(ptr) + k) % NUM_REQ;
        if (!gnt_vld && req_valid[cand]) begin
          gnt_vld            = 1'b1;
          gnt_idx            = cand;
          req_ready[cand]    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mul_a = op_a[15:0];
    mul_b = op_b[15:0];
    case (issue_idx)
      2'd0:    begin mul_a = op_a[15:0];  mul_b = op_b[15:0];  end
      2'd1:    begin mul_a = op_a[31:16]; mul_b = op_b[15:0];  end
      2'd2:    begin mul_a = op_a[15:0];  mul_b = op_b[31:16]; end
      default: begin mul_a = op_a[31:16]; mul_b = op_b[31:16]; end
    endcase
  end

  assign issue_vld = (state == ST_ISSUE);

  nios_sys_mul16_pipe #(
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p)
  );

  // Tags travel alongside the multiplier so each product knows its shift on arrival.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_idx[i] <= '0;
      end
    end else begin
      tag_vld[0] <= issue_vld;
      tag_idx[0] <= issue_idx;
      for (int i = 1; i < MUL_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  assign pp_vld   = tag_vld[MUL_LAT-1];
  assign pp_idx   = tag_idx[MUL_LAT-1];
  assign last_pp  = pp_vld && (pp_idx == 2'd3);
  assign acc_next = pp_vld ? acc + pp_align(mul_p, pp_idx) : acc;

`ifdef NIOS_SYS_MUL_SIGNED_EN
  // Two's-complement fix-up of the upper word for a signed interpretation of both operands.
  assign corr = (op_a[31] ? op_b : '0) + (op_b[31] ? op_a : '0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      cur_id     <= '0;
      issue_idx  <= '0;
      acc        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
`ifdef NIOS_SYS_MUL_SIGNED_EN
      cur_sgn    <= 1'b0;
`endif
    end else begin
      acc <= acc_next;
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            op_a      <= req_src1[gnt_idx*OP_W +: OP_W];
            op_b      <= req_src2[gnt_idx*OP_W +: OP_W];
            cur_id    <= ID_W'(gnt_idx);
            ptr       <= ID_W'((gnt_idx + 1) % NUM_REQ);
            acc       <= '0;
            issue_idx <= '0;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
`ifdef NIOS_SYS_MUL_SIGNED_EN
            cur_sgn   <= req_signed[gnt_idx];
`endif
          end
        end
        ST_ISSUE: begin
          issue_idx <= issue_idx + 2'd1;
          if (issue_idx == 2'd3) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (last_pp) begin
`ifdef NIOS_SYS_MUL_SIGNED_EN
            if (cur_sgn) begin
              state <= ST_CORR;
            end else begin
              rsp_result <= acc_next;
              rsp_id     <= cur_id;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end
`else
            rsp_result <= acc_next;
            rsp_id     <= cur_id;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
`endif
          end
        end
        ST_CORR: begin
`ifdef NIOS_SYS_MUL_SIGNED_EN
          rsp_result <= {acc[63:32] - corr, acc[31:0]};
          rsp_id     <= cur_id;
          rsp_valid  <= 1'b1;
          state      <= ST_RESP;
`else
          state      <= ST_IDLE;
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
